// File: rtl/multiplier_controller_pkg.sv
// Shared types and constants for the shift-add multiplier controller and datapath.
package multiplier_controller_pkg;

  localparam int WIDTH        = 3;   // operand width
  localparam int P_INIT       = 3;   // shift-add iterations per operation
  localparam int P_W          = 2;   // width of the datapath iteration down-counter
  localparam int CNT_W        = 3;   // width of the watchdog counter
  localparam int MAX_ITER_DEF = 4;   // default watchdog limit on ADD visits

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  // Debug view of the controller: current state plus the datapath strobes.
  typedef struct packed {
    state_e state;
    logic   load;
    logic   add;
    logic   shift;
    logic   dec;
  } dbg_t;

endpackage

// File: rtl/multiplier_controller_datapath.sv
// Shift-add datapath: carry C, accumulator A, multiplier Q, multiplicand M and an
// iteration down-counter P. Zbit flags P==0, Mbit is the current multiplier LSB.
module multiplier_controller_datapath
  import multiplier_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               add_i,
  input  logic               shift_i,
  input  logic               dec_i,
  input  logic [WIDTH-1:0]   a_in_i,
  input  logic [WIDTH-1:0]   b_in_i,
  output logic               zbit_o,
  output logic               mbit_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic             c_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [P_W-1:0]   p_q;

  // Register file update: load clears A and seeds M/Q/P, add accumulates M,
  // shift moves {C,A,Q} right by one bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= 1'b0;
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
    end else if (load_i) begin
      c_q <= 1'b0;
      a_q <= '0;
      q_q <= b_in_i;
      m_q <= a_in_i;
    end else if (add_i) begin
      {c_q, a_q} <= {1'b0, a_q} + {1'b0, m_q};
    end else if (shift_i) begin
      {c_q, a_q, q_q} <= {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
    end
  end

  // Iteration down-counter, reloaded on load and stepped alongside each shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else if (load_i) begin
      p_q <= P_W'(P_INIT);
    end else if (dec_i) begin
      p_q <= p_q - P_W'(1);
    end
  end

  assign zbit_o    = (p_q == '0);
  assign mbit_o    = q_q[0];
  assign product_o = {a_q, q_q};

endmodule

// File: rtl/multiplier_controller.sv
// Controller for a 3x3 unsigned shift-add multiplier with a watchdog on ADD visits.
//
// Handshake: a request is taken on any rising edge where start=1 and ready=1;
// inA/inB are captured on that same edge. The result is offered with done=1
// (or error=1 on a watchdog trip) and held until the first edge with ack=1,
// after which ready returns. start outside IDLE and ack outside DONE/ERROR
// are ignored.
module multiplier_controller
  import multiplier_controller_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic               ack,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2*WIDTH-1:0] product,
  output dbg_t               dbg
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [2*WIDTH-1:0] product_q;

  logic               load_regs, add_regs, shift_reg, decrement;
  logic               capture, prod_load;
  logic               zbit, mbit;
  logic [2*WIDTH-1:0] dp_product;

  multiplier_controller_datapath u_datapath (
    .clk       (clk),
    .rst       (reset),
    .load_i    (load_regs),
    .add_i     (add_regs),
    .shift_i   (shift_reg),
    .dec_i     (decrement),
    .a_in_i    (opa_q),
    .b_in_i    (opb_q),
    .zbit_o    (zbit),
    .mbit_o    (mbit),
    .product_o (dp_product)
  );

  // State, watchdog counter, captured operands and the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        opa_q <= inA;
        opb_q <= inB;
      end
      if (prod_load) begin
        product_q <= dp_product;
      end
    end
  end

  // Next-state and strobe decode; the watchdog check outranks Zbit in ADD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_regs = 1'b0;
    add_regs  = 1'b0;
    shift_reg = 1'b0;
    decrement = 1'b0;
    capture   = 1'b0;
    prod_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_regs = 1'b1;
        cnt_d     = '0;
        state_d   = S_ADD;
      end
      S_ADD: begin
        if (cnt_q == MAX_C) begin
          state_d = S_ERROR;
        end else if (zbit) begin
          prod_load = 1'b1;
          state_d   = S_DONE;
        end else begin
          add_regs = mbit;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_reg = 1'b1;
        decrement = 1'b1;
        state_d   = S_ADD;
      end
      S_DONE, S_ERROR: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_LOAD) || (state_q == S_ADD) || (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign error   = (state_q == S_ERROR);
  assign product = product_q;

  assign dbg.state = state_q;
  assign dbg.load  = load_regs;
  assign dbg.add   = add_regs;
  assign dbg.shift = shift_reg;
  assign dbg.dec   = decrement;

endmodule

// File: tb/tb_multiplier_controller.sv
// Bench for multiplier_controller: directed cases plus randomized operations,
// checked against an arithmetic reference (a*b, fixed 9-cycle schedule).
module tb_multiplier_controller;
  import multiplier_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ack;
  logic [2:0] inA;
  logic [2:0] inB;
  logic       ready, busy, done, error;
  logic [5:0] product;
  dbg_t       dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];
  logic [5:0] last_prod;

  multiplier_controller dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .inA     (inA),
    .inB     (inB),
    .ack     (ack),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .product (product),
    .dbg     (dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_strobes"}, {dbg.load, dbg.add, dbg.shift, dbg.dec}, 0);
  endtask

  // One full operation. noise: 0 quiet, 1 random start/ack/operands while busy,
  // 2 start held high with inA=1, inB=1 while busy.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input int ack_wait, input int noise);
    logic [5:0] exp_p;
    logic [5:0] got;
    exp_p = {3'b000, a} * {3'b000, b};
    check_eq("ready_before_start", ready, 1);
    inA   = a;
    inB   = b;
    start = 1'b1;
    step();
    exp_q.push_back(exp_p);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      check_eq("busy", busy, 1);
      check_eq("ready_while_busy", ready, 0);
      check_eq("done_early", done, 0);
      check_eq("error_unexpected", error, 0);
      check_eq("product_hold", product, last_prod);
      check_eq("load_strobe", dbg.load, (cyc == 1));
      if (cyc % 2 == 0) begin
        // ADD visit number cyc/2; the fourth one is the terminal check with no strobe
        if (cyc < 8) check_eq("add_strobe", dbg.add, b[cyc/2-1]);
        else         check_eq("add_strobe_final", dbg.add, 0);
        check_eq("shift_in_add", {dbg.shift, dbg.dec}, 0);
      end else if (cyc > 1) begin
        check_eq("shift_dec", {dbg.shift, dbg.dec}, 2'b11);
        check_eq("add_in_shift", dbg.add, 0);
      end
      case (noise)
        1: begin
          start = 1'($urandom_range(0, 1));
          ack   = 1'($urandom_range(0, 1));
          inA   = 3'($urandom_range(0, 7));
          inB   = 3'($urandom_range(0, 7));
        end
        2: begin
          start = 1'b1;
          inA   = 3'd1;
          inB   = 3'd1;
        end
        default: begin
          start = 1'b0;
        end
      endcase
      step();
    end
    start = 1'b0;
    ack   = 1'b0;
    if (exp_q.size() == 0) begin
      got = '0;
      check_eq("scoreboard_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
    end
    check_eq("done_at_t9", done, 1);
    check_eq("busy_in_done", busy, 0);
    check_eq("product", product, got);
    for (int w = 0; w < ack_wait; w++) begin
      step();
      check_eq("done_hold", done, 1);
      check_eq("product_stable", product, got);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_eq("ready_after_ack", ready, 1);
    check_eq("done_after_ack", done, 0);
    check_eq("product_after_ack", product, got);
    last_prod = got;
  endtask

  initial begin
    int err_cyc;
    int cyc;
    reset     = 1'b1;
    start     = 1'b0;
    ack       = 1'b0;
    inA       = '0;
    inB       = '0;
    last_prod = '0;
    #1;
    check_idle_outputs("in_reset");
    check_eq("product_in_reset", product, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check_idle_outputs("after_reset");

    // Directed cases
    run_op(3'd5, 3'd3, 0, 0);
    run_op(3'd7, 3'd7, 1, 0);
    run_op(3'd0, 3'd6, 0, 0);
    run_op(3'd6, 3'd4, 0, 2);
    run_op(3'd6, 3'd4, 5, 0);

    // Reset in the middle of an operation
    inA   = 3'd5;
    inB   = 3'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    check_eq("product_mid_reset", product, 0);
    step();
    reset = 1'b0;
    last_prod = '0;
    for (int c = 0; c < 10; c++) begin
      check_eq("no_done_after_reset", done, 0);
      step();
    end
    run_op(3'd2, 3'd3, 0, 0);

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    // Watchdog: Zbit stuck low means MAX_ITER+1 ADD visits, then ERROR
    force dut.u_datapath.zbit_o = 1'b0;
    inA   = 3'($urandom_range(0, 7));
    inB   = 3'($urandom_range(0, 7));
    start = 1'b1;
    step();
    start   = 1'b0;
    err_cyc = 0;
    cyc     = 1;
    while (cyc <= 20 && err_cyc == 0) begin
      check_eq("no_done_in_watchdog", done, 0);
      if (error === 1'b1) err_cyc = cyc;
      else begin
        step();
        cyc++;
      end
    end
    check_eq("watchdog_trip_cycle", err_cyc, 2 * (MAX_ITER_DEF + 1) + 1);
    check_eq("busy_in_error", busy, 0);
    check_eq("product_in_error", product, last_prod);
    repeat (3) step();
    check_eq("error_hold", error, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    release dut.u_datapath.zbit_o;
    check_idle_outputs("after_error_ack");

    run_op(3'd3, 3'd5, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multiplier_controller.md
MULTIPLIER_CONTROLLER -- requirements
Module: multiplier_controller

Interface
REQ-001 Parameter MAX_ITER, default 4: watchdog limit on ADD-state visits per operation.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 inA  input  3  multiplicand; sampled on the accepted-start cycle.
REQ-006 inB  input  3  multiplier; sampled on the accepted-start cycle.
REQ-007 ack  input  1  consumer acknowledge of done or error.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high in LOAD, ADD and SHIFT.
REQ-010 done  output  1  high only in DONE.
REQ-011 error  output  1  high only in ERROR (watchdog trip).
REQ-012 product  output  6  registered unsigned result, inA*inB.

Function
REQ-013 The FSM SHALL have six states: IDLE, LOAD, ADD, SHIFT, DONE and ERROR.
REQ-014 IDLE: start=1 -> capture inA/inB into operand registers, go to LOAD; else stay.
REQ-015 LOAD: assert loadRegs for exactly one cycle, clear iteration counter, go to ADD.
REQ-016 ADD, Zbit=1: no datapath strobe, go to DONE.
REQ-017 ADD, Zbit=0: addRegs=Mbit (combinational), increment iteration counter, go to SHIFT.
REQ-018 ADD, counter already equal to MAX_ITER: go to ERROR instead; this check takes priority over Zbit.
REQ-019 SHIFT: assert shiftReg and decrement together for one cycle, go to ADD.
REQ-020 DONE entry: product register loads the datapath {A,Q} on the ADD->DONE edge.
REQ-021 DONE/ERROR: hold until ack=1, then go to IDLE; ack in any other state is ignored.
REQ-022 start outside IDLE SHALL be ignored; no queuing.
REQ-023 At most one of loadRegs/addRegs/shiftReg SHALL be high per cycle; decrement is high only with shiftReg.
REQ-024 Latency: start accepted at edge T -> LOAD T+1, ADD/SHIFT alternating T+2..T+7, final ADD T+8, done=1 from T+9; 9 cycles fixed, independent of operand values.
REQ-025 The datapath SHALL be fed from the captured operand registers, never directly from inA/inB.
REQ-026 product SHALL hold its last value through IDLE and the next operation until the next DONE entry.
REQ-027 Iteration counter: 3 bits, saturating; it does not wrap.

Reset
REQ-028 reset SHALL asynchronously force IDLE, with product=0, operand registers=0 and iteration counter=0.
REQ-029 During reset, ready=1 and busy=done=error=0; all datapath strobes are 0.
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse; datapath contents are don't-care until the next LOAD.

Structure
REQ-031 State encoding, P_INIT=3, WIDTH=3 and the MAX_ITER default SHALL live in the shared multiplier package.
REQ-032 The block SHALL instantiate Datapath as its only sub-module, drive its strobes, and consume Zbit, Mbit and product.

Verification
REQ-033 Reset, then start with inA=5, inB=3 -> done at T+9, product=15; addRegs high in ADD cycles 1-2 only.
REQ-034 inA=7, inB=7 -> product=49; inA=0, inB=6 -> product=0; both with 9-cycle latency.
REQ-035 start pulsed during busy with inA=1, inB=1 -> ignored; first result (inA=6, inB=4 -> 24) unchanged.
REQ-036 Hold ack=0 for 5 cycles in DONE -> done stays high, product stable; ack=1 -> ready next cycle.
REQ-037 Assert reset at T+5 -> immediate IDLE, product=0, no done; a fresh start with inA=2, inB=3 -> product=6.
REQ-038 Force Zbit=0 in the Datapath instance -> error=1 after the 5th ADD visit; ack returns the FSM to IDLE.
